adc_scan_sequencer: RTL and testbench



---
 rtl/adc_scan_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer
// Description : Multi-channel SPI ADC scan sequencer (MCP3208-style frames).
//               Converts every channel set in a latched mask, lowest index
//               first, and returns each result tagged with its channel over a
//               valid/ready handshake. Single-scan and continuous-scan modes.
//               Optional macro ADC_TIMESTAMP_EN adds a 32-bit ts_o output
//               carrying the cycle count captured at each frame's cs_n fall.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
  parameter int WIDTH      = 12,
  parameter int NUM_CH     = 8,
  parameter int SPI_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int CMD_BITS   = 4,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [WIDTH-1:0]  data_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              adc_sclk_o,
  output logic              adc_cs_n_o,
  output logic              adc_mosi_o,
  input  logic              adc_miso_i
`ifdef ADC_TIMESTAMP_EN
  ,
  output logic [31:0]       ts_o
`endif
);

  localparam int DIV_W  = $clog2(SPI_DIV);
  localparam int HALF_W = $clog2(2 * FRAME_BITS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SPI_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HIGH  = 3'd3,
    S_OUTPUT   = 3'd4
  } state_t;

  // Lowest set channel of m at or above index 'from'; MSB flags "found".
  function automatic logic [CH_W:0] f_first(input logic [NUM_CH-1:0] m, input int from);
    logic [CH_W:0]   r;
    logic [NUM_CH-1:0] s;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      s = m >> i;
      if (s[0] && (i >= from)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  // Frame bit k: command {1, channel} MSB first, zeros after the command.
  function automatic logic f_frame_bit(input logic [CH_W-1:0] ch, input int k);
    logic [CMD_BITS-1:0] cmd;
    cmd = {1'b1, {(CMD_BITS - 1){1'b0}}} | CMD_BITS'(ch);
    cmd = cmd << k;
    return (k < CMD_BITS) ? cmd[CMD_BITS-1] : 1'b0;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [HALF_W-1:0]   r_half, w_half_nxt;
  logic [CH_W-1:0]     r_ch, w_ch_nxt;
  logic [NUM_CH-1:0]   r_mask, w_mask_nxt;
  logic [WIDTH-1:0]    r_shift, r_data;
  logic [CH_W-1:0]     r_ch_out;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_cs_n, w_cs_n_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic                w_sample, w_load_out, w_div_end;
  logic [CH_W:0]       w_first_new, w_next_ch;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic plus next values for counters, channel and SPI pins.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_half_nxt  = r_half;
    w_ch_nxt    = r_ch;
    w_mask_nxt  = r_mask;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_sample    = 1'b0;
    w_load_out  = 1'b0;
    w_div_end   = (r_div == DIV_LAST);
    w_first_new = f_first(ch_mask_i, 0);
    w_next_ch   = f_first(r_mask, int'(r_ch) + 1);
    case (r_state)
      S_IDLE: begin
        if (start_i && w_first_new[CH_W]) begin
          w_state_nxt = S_CS_SETUP;
          w_mask_nxt  = ch_mask_i;
          w_ch_nxt    = w_first_new[CH_W-1:0];
          w_div_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_CS_SETUP: begin
        if (w_div_end) begin
          // First rising SCLK edge: sample MISO bit 0.
          w_state_nxt = S_SHIFT;
          w_div_nxt   = '0;
          w_half_nxt  = '0;
          w_sample    = 1'b1;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          if (r_half == HALF_LAST) begin
            w_state_nxt = S_CS_HIGH;
          end else begin
            w_half_nxt = r_half + HALF_W'(1);
            // Leaving a low half-period means SCLK rises now.
            w_sample   = r_half[0];
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_CS_HIGH: begin
        if (w_div_end) begin
          w_state_nxt = S_OUTPUT;
          w_div_nxt   = '0;
          w_load_out  = 1'b1;
          w_valid_nxt = 1'b1;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_OUTPUT: begin
        if (ready_i) begin
          w_valid_nxt = 1'b0;
          w_div_nxt   = '0;
          if (w_next_ch[CH_W]) begin
            w_state_nxt = S_CS_SETUP;
            w_ch_nxt    = w_next_ch[CH_W-1:0];
          end else if (cont_i && w_first_new[CH_W]) begin
            // Wrap-around re-samples the live mask.
            w_state_nxt = S_CS_SETUP;
            w_mask_nxt  = ch_mask_i;
            w_ch_nxt    = w_first_new[CH_W-1:0];
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // SPI pins are registered from the next state so they never glitch.
    w_cs_n_nxt = !((w_state_nxt == S_CS_SETUP) || (w_state_nxt == S_SHIFT));
    w_sclk_nxt = (w_state_nxt == S_SHIFT) && !w_half_nxt[0];
    if (w_state_nxt == S_CS_SETUP)
      w_mosi_nxt = f_frame_bit(w_ch_nxt, 0);
    else if (w_state_nxt == S_SHIFT)
      w_mosi_nxt = f_frame_bit(w_ch_nxt, (int'(w_half_nxt) + 1) / 2);
    else
      w_mosi_nxt = 1'b0;
  end

  // Datapath registers: counters, mask/channel, shift register, result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_half   <= '0;
      r_ch     <= '0;
      r_mask   <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_ch_out <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_mosi   <= 1'b0;
    end else begin
      r_div   <= w_div_nxt;
      r_half  <= w_half_nxt;
      r_ch    <= w_ch_nxt;
      r_mask  <= w_mask_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_mosi  <= w_mosi_nxt;
      if (w_sample) r_shift <= {r_shift[WIDTH-2:0], adc_miso_i};
      if (w_load_out) begin
        r_data   <= r_shift;
        r_ch_out <= r_ch;
      end
    end
  end

  assign data_o     = r_data;
  assign ch_o       = r_ch_out;
  assign valid_o    = r_valid;
  assign busy_o     = r_busy;
  assign adc_sclk_o = r_sclk;
  assign adc_cs_n_o = r_cs_n;
  assign adc_mosi_o = r_mosi;

`ifdef ADC_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;
  logic [31:0] r_ts_cap;

  // Free-running cycle counter; snapshot taken when cs_n is about to fall.
  // The snapshot only changes at the next frame start, which follows the
  // acceptance of the current result, so ts_o is stable while valid_o is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_cnt <= '0;
      r_ts_cap <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if (r_cs_n && !w_cs_n_nxt) r_ts_cap <= r_ts_cnt;
    end
  end

  assign ts_o = r_ts_cap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_sequencer
// Description : Self-checking bench for adc_scan_sequencer with an ADC model
//               on the SPI pins and a result/command scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

  localparam int WIDTH = 12;
  localparam int NUM_CH = 8;
  localparam int SPI_DIV = 4;
  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS = 4;
  localparam int CH_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              cont_i = 1'b0;
  logic              ready_i = 1'b1;
  logic              adc_miso_i = 1'b0;
  logic [NUM_CH-1:0] ch_mask_i = '0;
  logic [WIDTH-1:0]  data_o;
  logic [CH_W-1:0]   ch_o;
  logic              valid_o, busy_o, adc_sclk_o, adc_cs_n_o, adc_mosi_o;
`ifdef ADC_TIMESTAMP_EN
  logic [31:0]       ts_o;
`endif

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .SPI_DIV(SPI_DIV),
    .FRAME_BITS(FRAME_BITS), .CMD_BITS(CMD_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cont_i(cont_i),
    .ch_mask_i(ch_mask_i), .data_o(data_o), .ch_o(ch_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .adc_sclk_o(adc_sclk_o),
    .adc_cs_n_o(adc_cs_n_o), .adc_mosi_o(adc_mosi_o), .adc_miso_i(adc_miso_i)
`ifdef ADC_TIMESTAMP_EN
    , .ts_o(ts_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Conversion value the ADC model returns per channel.
  function automatic logic [11:0] adc_val(input int ch);
    case (ch)
      0:       return 12'hA5C;
      2:       return 12'h3F1;
      default: return 12'(12'h0F0 + 12'h111 * ch);
    endcase
  endfunction

  logic [CH_W+WIDTH-1:0] exp_q[$];
  logic [CH_W-1:0]       cmd_q[$];

  task automatic push_scan(input logic [NUM_CH-1:0] m);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m[i]) begin
        exp_q.push_back({CH_W'(i), adc_val(i)});
        cmd_q.push_back(CH_W'(i));
      end
    end
  endtask

  // ADC model, frame monitor and result scoreboard, all at negedge clk.
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  int          rise_idx = 0;
  logic [3:0]  cmd_bits = '0;
  logic [11:0] rsp = '0;
  int          n_csfall = 0, n_acc = 0;
  int          gap_cnt = 0, min_gap = 1000;
  logic [CH_W+WIDTH-1:0] e_item;
  logic [CH_W-1:0]       e_ch;
`ifdef ADC_TIMESTAMP_EN
  logic [31:0] ts_last = '0, ts_diff = '0;
  bit          ts_have = 1'b0;
`endif

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk  = 1'b0;
      prev_cs    = 1'b1;
      rise_idx   = 0;
      adc_miso_i = 1'b0;
      gap_cnt    = 0;
    end else begin
      if (prev_cs && !adc_cs_n_o) begin
        n_csfall++;
        rise_idx   = 0;
        cmd_bits   = '0;
        adc_miso_i = 1'b0;
        if (gap_cnt > 0 && gap_cnt < min_gap) min_gap = gap_cnt;
        gap_cnt = 0;
      end
      if (!busy_o) gap_cnt = 0;
      else if (adc_cs_n_o) gap_cnt++;
      if (!prev_sclk && adc_sclk_o) begin
        if (rise_idx < CMD_BITS) cmd_bits = {cmd_bits[2:0], adc_mosi_o};
        rise_idx++;
        if (rise_idx == CMD_BITS) begin
          rsp = adc_val(int'(cmd_bits[2:0]));
          check_val("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
          if (cmd_q.size() != 0) begin
            e_ch = cmd_q.pop_front();
            check_val("mosi_cmd", 32'(cmd_bits), 32'({1'b1, e_ch}));
          end
        end
      end
      if (prev_sclk && !adc_sclk_o) begin
        if (rise_idx >= CMD_BITS && rise_idx < FRAME_BITS) adc_miso_i = rsp[FRAME_BITS-1-rise_idx];
        else adc_miso_i = 1'b0;
      end
      prev_sclk = adc_sclk_o;
      prev_cs   = adc_cs_n_o;

      if (valid_o && ready_i) begin
        n_acc++;
        check_val("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_item = exp_q.pop_front();
          check_val("ch_o", 32'(ch_o), 32'(e_item[CH_W+WIDTH-1:WIDTH]));
          check_val("data_o", 32'(data_o), 32'(e_item[WIDTH-1:0]));
        end
`ifdef ADC_TIMESTAMP_EN
        if (ts_have) ts_diff = ts_o - ts_last;
        ts_last = ts_o;
        ts_have = 1'b1;
`endif
      end
    end
  end

  task automatic start_scan(input logic [NUM_CH-1:0] m, input bit push);
    @(posedge clk); #1;
    ch_mask_i = m;
    if (push) push_scan(m);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_o && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check_val(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!valid_o && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check_val(tag, 32'(valid_o), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc0, nf, k;
    bit stable, saw_busy;
    logic [WIDTH-1:0] d;
    logic [CH_W-1:0]  c;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data", 32'(data_o), 32'd0);
    check_val("rst_ch", 32'(ch_o), 32'd0);
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_sclk", 32'(adc_sclk_o), 32'd0);
    check_val("rst_cs_n", 32'(adc_cs_n_o), 32'd1);
    check_val("rst_mosi", 32'(adc_mosi_o), 32'd0);
    rst_n = 1'b1;

    // Basic two-channel scan with latency measurement
    acc0 = n_acc;
    start_scan(8'h05, 1'b1);
    lat = 1;
    check_val("busy_rise", 32'(busy_o), 32'd1);
    while (!valid_o && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("first_valid_latency", 32'(lat), 32'd137);
    wait_idle("scan_a_idle");
    check_val("scan_a_results", 32'(n_acc - acc0), 32'd2);
`ifdef ADC_TIMESTAMP_EN
    check_val("ts_delta", ts_diff, 32'(SPI_DIV * (2 * FRAME_BITS + 2) + 1));
`endif

    // Back-pressure: hold the first result for 50 cycles
    ready_i = 1'b0;
    acc0 = n_acc;
    start_scan(8'h05, 1'b1);
    wait_valid("stall_valid");
    d = data_o;
    c = ch_o;
    nf = n_csfall;
    stable = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (data_o !== d || ch_o !== c || valid_o !== 1'b1) stable = 1'b0;
    end
    check_val("stall_stable", 32'(stable), 32'd1);
    check_val("stall_held_data", 32'(d), 32'h0A5C);
    check_val("stall_no_cs", 32'(n_csfall), 32'(nf));
    check_val("stall_cs_high", 32'(adc_cs_n_o), 32'd1);
    ready_i = 1'b1;
    wait_idle("stall_idle");
    check_val("stall_results", 32'(n_acc - acc0), 32'd2);

    // Empty mask: start ignored
    nf = n_csfall;
    saw_busy = 1'b0;
    start_scan(8'h00, 1'b0);
    repeat (30) begin
      @(posedge clk); #1;
      if (busy_o) saw_busy = 1'b1;
    end
    check_val("mask0_busy", 32'(saw_busy), 32'd0);
    check_val("mask0_no_cs", 32'(n_csfall), 32'(nf));

    // start_i during SHIFT is ignored
    acc0 = n_acc;
    start_scan(8'h12, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    ch_mask_i = 8'hFF;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_idle("restart_idle");
    check_val("restart_results", 32'(n_acc - acc0), 32'd2);
    check_val("restart_queue", 32'(exp_q.size()), 32'd0);

    // Continuous mode on channel 7, cont_i dropped during the third frame
    acc0 = n_acc;
    min_gap = 1000;
    cont_i = 1'b1;
    start_scan(8'h80, 1'b1);
    push_scan(8'h80);
    push_scan(8'h80);
    k = 0;
    while ((n_acc - acc0) < 2 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("cont_two_frames", 32'(n_acc - acc0), 32'd2);
    repeat (20) @(posedge clk);
    #1;
    cont_i = 1'b0;
    wait_idle("cont_idle");
    check_val("cont_results", 32'(n_acc - acc0), 32'd3);
    check_val("cont_gap_ge_div", 32'(min_gap >= SPI_DIV), 32'd1);

    // Asynchronous reset in the middle of SHIFT
    start_scan(8'h05, 1'b1);
    repeat (50) @(posedge clk);
    #3;
    check_val("pre_rst_cs_low", 32'(adc_cs_n_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("midrst_cs_n", 32'(adc_cs_n_o), 32'd1);
    check_val("midrst_sclk", 32'(adc_sclk_o), 32'd0);
    check_val("midrst_valid", 32'(valid_o), 32'd0);
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    cmd_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc0 = n_acc;
    start_scan(8'h05, 1'b1);
    wait_idle("post_rst_idle");
    check_val("post_rst_results", 32'(n_acc - acc0), 32'd2);
    check_val("post_rst_queue", 32'(exp_q.size()), 32'd0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
